// File: rtl/deserializer_if.sv
// Serial input / parallel output bundle between the bit source, the deserializer
// and the downstream queue.
interface deserializer_if;
  logic       data_in;
  logic       write_in;
  logic       ack_in;
  logic [7:0] data_out;
  logic       data_ready;
  logic       status_out;
  logic [3:0] bit_count_out;
  logic       overrun_out;

  modport master (
    output data_in, write_in, ack_in,
    input  data_out, data_ready, status_out, bit_count_out, overrun_out
  );

  modport slave (
    input  data_in, write_in, ack_in,
    output data_out, data_ready, status_out, bit_count_out, overrun_out
  );
endinterface

// File: rtl/deserializer.sv
// MSB-first 8-bit serial-to-parallel stage; holds each completed word until it is
// acknowledged, dropping (and flagging) bits that arrive meanwhile.
module deserializer (
  input  logic         clock_10,
  input  logic         reset,
  deserializer_if.slave bus
);

  typedef enum logic {SHIFT, HOLD} state_t;

  state_t     state;
  state_t     next_state;
  logic [6:0] shift_reg;
  logic [3:0] count;
  logic [7:0] word;
  logic       overrun;

  always_ff @(posedge clock_10 or negedge reset) begin
    if (!reset) state <= SHIFT;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      SHIFT: if (bus.write_in && count == 4'd7) next_state = HOLD;
      HOLD:  if (bus.ack_in)                    next_state = SHIFT;
      default: next_state = SHIFT;
    endcase
  end

  // Only seven bits are ever buffered: the eighth goes straight into the word.
  always_ff @(posedge clock_10 or negedge reset) begin
    if (!reset) begin
      shift_reg <= '0;
      count     <= '0;
      word      <= '0;
      overrun   <= 1'b0;
    end else begin
      unique case (state)
        SHIFT: begin
          if (bus.write_in) begin
            if (count == 4'd7) begin
              word  <= {shift_reg, bus.data_in};
              count <= 4'd8;
            end else begin
              shift_reg <= {shift_reg[5:0], bus.data_in};
              count     <= count + 4'd1;
            end
          end
        end
        HOLD: begin
          if (bus.ack_in) begin
            if (bus.write_in) begin
              shift_reg <= {6'b0, bus.data_in};
              count     <= 4'd1;
            end else begin
              count <= 4'd0;
            end
          end else if (bus.write_in) begin
            overrun <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.data_ready    = (state == HOLD);
    bus.status_out    = (state == HOLD);
    bus.data_out      = word;
    bus.bit_count_out = count;
    bus.overrun_out   = overrun;
  end

endmodule

// File: tb/tb_deserializer.sv
// Directed bench for deserializer, with a small queue model standing in for the
// downstream FIFO (ack = data_ready && len < 8, enqueue on ready && ack).
module tb_deserializer;

  logic clock_10 = 1'b0;
  logic reset    = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  logic [7:0] enq_log[$];
  int   qlen;

  deserializer_if bus();

  deserializer dut (
    .clock_10 (clock_10),
    .reset    (reset),
    .bus      (bus.slave)
  );

  always #50 clock_10 = ~clock_10;

  always @(posedge clock_10)
    if (reset && bus.data_ready && bus.ack_in) enq_log.push_back(bus.data_out);

  initial begin
    #5_000_000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic cycle(input logic w, input logic d, input logic a);
    @(negedge clock_10);
    bus.write_in = w;
    bus.data_in  = d;
    bus.ack_in   = a;
    @(posedge clock_10);
    #1;
  endtask

  task automatic send_word(input logic [7:0] w, input bit gapped);
    for (int unsigned j = 0; j < 8; j++) begin
      cycle(1'b1, w[7-j], 1'b0);
      check("count_step", {4'h0, bus.bit_count_out}, 8'(j + 1));
      if (gapped) begin
        for (int unsigned g = 0; g < j % 4; g++) begin
          cycle(1'b0, 1'b1, 1'b0);
          check("count_gap", {4'h0, bus.bit_count_out}, 8'(j + 1));
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clock_10);
    bus.write_in = 1'b1;
    bus.data_in  = 1'b1;
    bus.ack_in   = 1'b1;
    reset = 1'b0;
    @(negedge clock_10);
    reset = 1'b1;
    bus.write_in = 1'b0;
    bus.ack_in   = 1'b0;
  endtask

  initial begin
    bus.data_in  = 1'b1;
    bus.write_in = 1'b1;
    bus.ack_in   = 1'b1;
    repeat (2) @(posedge clock_10);
    #1;
    check("rst_count_during", {4'h0, bus.bit_count_out}, 8'h00);
    @(negedge clock_10);
    reset = 1'b1;
    bus.write_in = 1'b0;
    bus.ack_in   = 1'b0;
    #1;
    check("rst_data", bus.data_out, 8'h00);
    check("rst_ready", {7'h0, bus.data_ready}, 8'h00);
    check("rst_status", {7'h0, bus.status_out}, 8'h00);
    check("rst_count", {4'h0, bus.bit_count_out}, 8'h00);
    check("rst_overrun", {7'h0, bus.overrun_out}, 8'h00);

    // basic word, consecutive bits
    send_word(8'hA5, 1'b0);
    check("basic_data", bus.data_out, 8'hA5);
    check("basic_ready", {7'h0, bus.data_ready}, 8'h01);
    check("basic_status", {7'h0, bus.status_out}, 8'h01);
    check("basic_count", {4'h0, bus.bit_count_out}, 8'h08);
    cycle(1'b0, 1'b0, 1'b1);
    check("basic_ack_ready", {7'h0, bus.data_ready}, 8'h00);
    check("basic_ack_status", {7'h0, bus.status_out}, 8'h00);
    check("basic_ack_count", {4'h0, bus.bit_count_out}, 8'h00);
    check("basic_ack_keep", bus.data_out, 8'hA5);
    cycle(1'b0, 1'b0, 1'b1);
    check("ack_in_shift", {4'h0, bus.bit_count_out}, 8'h00);

    // gapped word
    send_word(8'hA5, 1'b1);
    check("gap_data", bus.data_out, 8'hA5);
    check("gap_ready", {7'h0, bus.data_ready}, 8'h01);
    cycle(1'b0, 1'b0, 1'b1);

    // overrun while held
    send_word(8'h3C, 1'b0);
    check("ovr_data0", bus.data_out, 8'h3C);
    check("ovr_flag0", {7'h0, bus.overrun_out}, 8'h00);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    check("ovr_data", bus.data_out, 8'h3C);
    check("ovr_flag", {7'h0, bus.overrun_out}, 8'h01);
    check("ovr_count", {4'h0, bus.bit_count_out}, 8'h08);
    check("ovr_ready", {7'h0, bus.data_ready}, 8'h01);
    cycle(1'b0, 1'b0, 1'b1);
    check("ovr_after_ack_ready", {7'h0, bus.data_ready}, 8'h00);
    check("ovr_sticky", {7'h0, bus.overrun_out}, 8'h01);

    // back-to-back with simultaneous ack and first bit
    do_reset();
    #1;
    check("b2b_overrun_cleared", {7'h0, bus.overrun_out}, 8'h00);
    enq_log.delete();
    send_word(8'hFF, 1'b0);
    check("b2b_first", bus.data_out, 8'hFF);
    cycle(1'b1, 1'b0, 1'b1);
    check("b2b_ready_low", {7'h0, bus.data_ready}, 8'h00);
    check("b2b_count1", {4'h0, bus.bit_count_out}, 8'h01);
    for (int unsigned j = 0; j < 7; j++) cycle(1'b1, (j == 6), 1'b0);
    check("b2b_second", bus.data_out, 8'h01);
    check("b2b_ready", {7'h0, bus.data_ready}, 8'h01);
    check("b2b_overrun", {7'h0, bus.overrun_out}, 8'h00);
    cycle(1'b0, 1'b0, 1'b1);
    check("b2b_enq_n", 8'(enq_log.size()), 8'h02);
    if (enq_log.size() == 2) begin
      check("b2b_enq0", enq_log[0], 8'hFF);
      check("b2b_enq1", enq_log[1], 8'h01);
    end

    // asynchronous reset mid-word, then queue backpressure
    for (int unsigned j = 0; j < 4; j++) cycle(1'b1, 1'b1, 1'b0);
    check("mid_count4", {4'h0, bus.bit_count_out}, 8'h04);
    #20 reset = 1'b0;
    #1;
    check("mid_async_count", {4'h0, bus.bit_count_out}, 8'h00);
    check("mid_async_data", bus.data_out, 8'h00);
    @(negedge clock_10);
    bus.write_in = 1'b0;
    reset = 1'b1;
    enq_log.delete();
    send_word(8'h5A, 1'b0);
    check("mid_data", bus.data_out, 8'h5A);
    qlen = 8;
    repeat (3) cycle(1'b0, 1'b0, bus.data_ready && (qlen < 8));
    check("stall_ready", {7'h0, bus.data_ready}, 8'h01);
    check("stall_data", bus.data_out, 8'h5A);
    check("stall_no_enq", 8'(enq_log.size()), 8'h00);
    qlen = 7;
    cycle(1'b0, 1'b0, bus.data_ready && (qlen < 8));
    check("release_ready", {7'h0, bus.data_ready}, 8'h00);
    check("release_enq_n", 8'(enq_log.size()), 8'h01);
    if (enq_log.size() == 1) check("release_enq", enq_log[0], 8'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/deserializer.md
# deserializer

Serial-to-parallel input stage upstream of the 8-entry FIFO queue. Collects one bit per qualified clock edge, MSB first, into an 8-bit word and presents it with a level `data_ready` flag. The word is held until the downstream side acknowledges it, which gives the queue backpressure over the serial source. Bits that arrive while a word is held unacknowledged are dropped and flagged.

## Interface
- No parameters; word width fixed at 8, bit order fixed MSB-first.
- `clock_10` in 1 — system clock (10 kHz); all state changes on rising edge.
- `reset` in 1 — asynchronous, active-low; `reset`=0 forces reset state immediately, release synchronous to `clock_10`.
- `data_in` in 1 — serial bit, sampled when `write_in`=1.
- `write_in` in 1 — bit-valid qualifier; one bit consumed per edge with `write_in`=1.
- `ack_in` in 1 — consumer accepted the held word; ignored when `data_ready`=0.
- `data_out` out 8 — last completed word; stable while `data_ready`=1.
- `data_ready` out 1 — level; completed word is waiting for acknowledgement.
- `status_out` out 1 — busy: 1 while in HOLD (new bits will be dropped).
- `bit_count_out` out 4 — bits currently assembled: 0–7 in SHIFT, 8 in HOLD.
- `overrun_out` out 1 — sticky; set when a bit is dropped in HOLD; cleared only by reset.

## Operation
- Reset values: `data_out`=8'h00, `data_ready`=0, `status_out`=0, `bit_count_out`=0, `overrun_out`=0, internal shift register=0, state=SHIFT.
- States: SHIFT (assembling), HOLD (word complete, awaiting ack).
- SHIFT, `write_in`=1, count<7: shift_reg <= {shift_reg[6:0], data_in}, count+1.
- SHIFT, `write_in`=1, count=7: `data_out` <= {shift_reg[6:0], data_in}, `data_ready`<=1, `status_out`<=1, count<=8, state HOLD.
- SHIFT, `write_in`=0: no change; gaps of any length between bits are allowed.
- HOLD, `ack_in`=0, `write_in`=1: bit discarded, `overrun_out`<=1, `data_out` unchanged.
- HOLD, `ack_in`=1: `data_ready`<=0, `status_out`<=0, state SHIFT. If `write_in`=1 on the same edge, that bit is accepted as bit 7 (first bit) of the next word: shift_reg <= {7'b0, data_in}, count<=1. Otherwise count<=0. No overrun in this case.
- `ack_in` in SHIFT: ignored, no side effect.
- `data_out` keeps the last word after ack until the next word completes.
- Integration: top level drives `ack_in` = `data_ready` && (queue `len_out` < 8), and queue `enq_in` = `data_ready` && `ack_in`, with `data_in` of the queue from `data_out`. The word is enqueued and released on the same edge, so it is never enqueued twice.

## Timing
- Latency: word visible on `data_out` with `data_ready`=1 immediately after the edge that samples the 8th bit (0 extra cycles).
- Release: `data_ready` falls after the edge sampling `ack_in`=1.
- Max throughput: one word per 8 qualified edges when `ack_in` is asserted on the first edge of HOLD.
- Minimum HOLD duration: 1 cycle.
- Reset mid-word or mid-HOLD: partial bits and the held word are lost. All outputs return to reset values asynchronously. The first bit after release starts a fresh word.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset: drive `reset`=0 with arbitrary inputs, then release -> all outputs 0, `bit_count_out`=0.
- Basic word: bits 1,0,1,0,0,1,0,1 on 8 consecutive edges with `write_in`=1 -> after 8th edge `data_out`=8'hA5, `data_ready`=1, `status_out`=1, `bit_count_out`=8. Pulse `ack_in` -> `data_ready`=0, count=0.
- Gapped input: same bits with 0–3 idle cycles (`write_in`=0) between them -> `data_out`=8'hA5; count holds during gaps.
- Overrun: complete 8'h3C, hold `ack_in`=0, send 3 more bits -> `data_out` stays 8'h3C, `overrun_out`=1; it stays 1 after a later ack.
- Back-to-back with simultaneous ack: complete 8'hFF, assert `ack_in` and `write_in` (data 0) on the same edge, then 7 bits 0000001 -> second word 8'h01, `overrun_out`=0. Queue-connected bench sees 8'hFF then 8'h01 enqueued once each.
- Reset mid-operation: 4 bits in, assert `reset`=0 for 1 cycle, then send 8'h5A -> `data_out`=8'h5A, no residue from the partial word; a queue at `len_out`=8 stalls via `ack_in`=0 with `data_ready` held.
